mr_accum_alu: RTL and testbench
===============================

Name: mr_accum_alu

Overview:
- Parametrised, registered successor to the 16-bit add/sub/zero arithmetic unit.
- The accumulator is held inside the block, so no external accumulator feedback input is needed.
- Adds carry-chained add, logic ops, a multi-cycle iterative left shift and a multi-cycle shift-add multiply, with a START/BUSY/DONE handshake and C/Z/N flags.
- Sits in the datapath between the operand bus (D_IN) and the accumulator consumers.

Parameters:
- WIDTH, 16: datapath and accumulator width; legal range is 4 or more.
- CNT_W, $clog2(WIDTH): width of the shift-amount field and the iteration counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  operation request; sampled only in IDLE.
- OP  in  3  operation code; sampled on the START edge.
- D_IN  in  WIDTH  operand; sampled on the START edge.
- AH_ACC  out  WIDTH  accumulator value (registered).
- BUSY  out  1  high while a multi-cycle op is in progress.
- DONE  out  1  one-cycle pulse; result and flags are valid in that cycle.
- C_FLAG  out  1  carry/borrow/shift-out/overflow flag.
- Z_FLAG  out  1  result == 0.
- N_FLAG  out  1  result MSB.

Behaviour:
- Reset: AH_ACC=0, all flags=0, BUSY=0, DONE=0, state=IDLE. Reset has priority over everything; asserting it mid-operation aborts with no DONE.
- States: IDLE, SHIFT, MUL.
- "Edge 0" is the edge that samples START=1 in IDLE. START is ignored in SHIFT and MUL, and OP/D_IN are don't-care there.
- Single-cycle ops: the result is written at edge 0. DONE=1 in the following cycle only; BUSY stays 0. The op codes are:
  - 000 ADD: ACC+D_IN; C = carry out.
  - 001 SUB: ACC-D_IN mod 2^WIDTH; C = borrow (1 when D_IN > ACC, unsigned).
  - 010 CLR: ACC=0; C=0.
  - 011 LOAD: ACC=D_IN; C=0.
  - 100 AND: ACC&D_IN; C=0.
  - 101 ADC: ACC+D_IN+C_FLAG; C = carry out.
- 110 SHL (amount n = D_IN[CNT_W-1:0]):
  - n=0: behaves as a single-cycle op; ACC unchanged, C=0.
  - n≥1: edge 0 latches n and enters SHIFT; AH_ACC is unchanged at edge 0. Edges 1..n each shift AH_ACC left by one bit with zero fill, C = the bit shifted out.
  - At edge n: state goes to IDLE and DONE=1 next cycle. BUSY=1 for exactly n cycles (after edges 0..n-1).
  - AH_ACC is visible mid-shift.
- 111 MUL: result = (ACC*D_IN) mod 2^WIDTH.
  - Edge 0 latches multiplicand=ACC and multiplier=D_IN, clears a 2*WIDTH-bit product register, and enters MUL.
  - Edges 1..WIDTH each perform one shift-add iteration. AH_ACC holds its old value throughout.
  - At edge WIDTH: AH_ACC = product low half; C = OR of the product high half (overflow). DONE next cycle; BUSY=1 for WIDTH cycles.
- Flags: Z and N are computed from the final result and updated only on the edge that writes the final result. Mid-SHL, C tracks each shift-out; Z and N update at the last shift.
- DONE is never asserted in two consecutive cycles unless back-to-back single-cycle ops are issued. A START in the DONE cycle is accepted, since the state is IDLE.
- Arithmetic is unsigned modulo 2^WIDTH; there is no saturation.

Decomposition:
- Package mr_alu_pkg:
  - op-code localparams OP_ADD..OP_MUL;
  - state enum (IDLE, SHIFT, MUL);
  - width helper function.
- One sub-module, mr_alu_core: combinational ADD/SUB/ADC/AND/CLR/LOAD with carry out. The sequencer, shifter iteration and multiplier iteration stay in the top level.

Test Plan (WIDTH=16):
- Reset, then LOAD D_IN=0x1234 → next cycle AH_ACC=0x1234, DONE=1 for 1 cycle, Z=0, N=0, C=0, BUSY=0 throughout.
- ACC=0xFFFF, ADD 0x0001 → AH_ACC=0x0000, C=1, Z=1. Then ADC 0x0000 → AH_ACC=0x0001, C=0, Z=0.
- ACC=0x0003, SUB 0x0005 → AH_ACC=0xFFFE, C=1, N=1. Then ACC=0x0005, SUB 0x0005 → 0x0000, C=0, Z=1.
- ACC=0x8001, SHL D_IN=0x0003 → BUSY high 3 cycles; intermediate values 0x0002 (C=1), 0x0004, 0x0008; final C=0, DONE once. A START with LOAD 0xAAAA while BUSY is ignored. SHL with n=0 → DONE next cycle, ACC unchanged, C=0.
- ACC=0x0012, MUL 0x0034 → BUSY 16 cycles, AH_ACC stays 0x0012, then 0x03A8 with C=0. ACC=0x0100, MUL 0x0300 → 0x0000, C=1, Z=1.
- Start MUL, assert RESET in the 5th BUSY cycle → next cycle AH_ACC=0, flags=0, BUSY=0, no DONE at any later cycle. A subsequent LOAD 0x0001 completes normally.

Source files
------------

// File: rtl/mr_accum_alu_pkg.sv
// Shared op codes, sequencer states and sizing helper for the accumulator ALU.
// Pure declarations: no logic and no timing.
package mr_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_CLR  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_ADC  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MUL
    } state_t;

    // The shift-add multiplier carries a full double-width product.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mr_accum_alu_if.sv
// Operand/result bus of the accumulator ALU: request side in, accumulator and flags out.
// No storage; START is only honoured while the block is idle.
interface mr_accum_alu_if #(
    parameter int WIDTH = 16
);
    logic             START;
    logic [2:0]       OP;
    logic [WIDTH-1:0] D_IN;
    logic [WIDTH-1:0] AH_ACC;
    logic             BUSY;
    logic             DONE;
    logic             C_FLAG;
    logic             Z_FLAG;
    logic             N_FLAG;

    modport master (
        output START, OP, D_IN,
        input  AH_ACC, BUSY, DONE, C_FLAG, Z_FLAG, N_FLAG
    );

    modport slave (
        input  START, OP, D_IN,
        output AH_ACC, BUSY, DONE, C_FLAG, Z_FLAG, N_FLAG
    );
endinterface

// File: rtl/mr_accum_alu_core.sv
// Combinational single-cycle ops (ADD/SUB/ADC/AND/CLR/LOAD) with carry/borrow out.
// Zero latency, no backpressure; other op codes pass the accumulator through with carry 0.
module mr_alu_core
    import mr_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] d_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] res,
    output logic             c_out
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide  = '0;
        res   = acc;
        c_out = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, acc} + {1'b0, d_in};
                res   = wide[WIDTH-1:0];
                c_out = wide[WIDTH];
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the unsigned borrow.
                wide  = {1'b0, acc} - {1'b0, d_in};
                res   = wide[WIDTH-1:0];
                c_out = wide[WIDTH];
            end
            OP_ADC: begin
                wide  = {1'b0, acc} + {1'b0, d_in} + {{WIDTH{1'b0}}, c_in};
                res   = wide[WIDTH-1:0];
                c_out = wide[WIDTH];
            end
            OP_CLR:  res = '0;
            OP_LOAD: res = d_in;
            OP_AND:  res = acc & d_in;
            default: ;
        endcase
    end

endmodule

// File: rtl/mr_accum_alu.sv
// Registered accumulator ALU: single-cycle ops done next cycle, SHL n takes n cycles, MUL WIDTH cycles.
// No input backpressure: START while BUSY is dropped; DONE is a one-cycle pulse.
module mr_accum_alu
    import mr_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    mr_accum_alu_if.slave bus
);

    localparam int PW = prod_w(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, mcand, mplier, addend, core_res, shl_res;
    logic [PW-1:0]    prod, prod_nxt;
    logic [WIDTH:0]   mul_sum;
    logic [CNT_W-1:0] cnt, shamt;
    logic             c_q, z_q, n_q, done_q, core_c, busy;

    assign shamt = bus.D_IN[CNT_W-1:0];

    mr_alu_core #(.WIDTH(WIDTH)) u_core (
        .op    (bus.OP),
        .acc   (acc),
        .d_in  (bus.D_IN),
        .c_in  (c_q),
        .res   (core_res),
        .c_out (core_c)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    if (bus.OP == OP_MUL)                        state_nxt = MUL;
                    else if (bus.OP == OP_SHL && shamt != '0)   state_nxt = SHIFT;
                end
            end
            SHIFT, MUL: if (cnt == '0) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        case (state)
            SHIFT, MUL: busy = 1'b1;
            default:    busy = 1'b0;
        endcase
    end

    // One right-shifting shift-add step: the LSB of the multiplier selects the addend.
    always_comb begin
        addend   = mplier[0] ? mcand : '0;
        mul_sum  = {1'b0, prod[PW-1:WIDTH]} + {1'b0, addend};
        prod_nxt = {mul_sum, prod[WIDTH-1:1]};
        shl_res  = {acc[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc    <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        if (bus.OP == OP_MUL) begin
                            mcand  <= acc;
                            mplier <= bus.D_IN;
                            prod   <= '0;
                            cnt    <= CNT_W'(WIDTH - 1);
                        end else if (bus.OP == OP_SHL && shamt != '0) begin
                            cnt <= shamt - 1'b1;
                        end else begin
                            // SHL by zero falls through here: core passes acc with carry 0.
                            acc    <= core_res;
                            c_q    <= core_c;
                            z_q    <= (core_res == '0);
                            n_q    <= core_res[WIDTH-1];
                            done_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    acc <= shl_res;
                    c_q <= acc[WIDTH-1];
                    if (cnt == '0) begin
                        z_q    <= (shl_res == '0);
                        n_q    <= shl_res[WIDTH-1];
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MUL: begin
                    prod   <= prod_nxt;
                    mplier <= mplier >> 1;
                    if (cnt == '0) begin
                        acc    <= prod_nxt[WIDTH-1:0];
                        c_q    <= |prod_nxt[PW-1:WIDTH];
                        z_q    <= (prod_nxt[WIDTH-1:0] == '0);
                        n_q    <= prod_nxt[WIDTH-1];
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.AH_ACC = acc;
    assign bus.BUSY   = busy;
    assign bus.DONE   = done_q;
    assign bus.C_FLAG = c_q;
    assign bus.Z_FLAG = z_q;
    assign bus.N_FLAG = n_q;

endmodule

// File: tb/tb_mr_accum_alu.sv
// Scoreboard bench for mr_accum_alu at WIDTH=16: directed ops push expected results, a DONE monitor pops them.
module tb_mr_accum_alu;
    import mr_alu_pkg::*;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    mr_accum_alu_if #(.WIDTH(16)) bus();

    mr_accum_alu #(.WIDTH(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] acc;
        logic        c;
        logic        z;
        logic        n;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] a, input logic c);
        exp_t e;
        e.acc = a;
        e.c   = c;
        e.z   = (a == 16'h0000);
        e.n   = a[15];
        return e;
    endfunction

    task automatic expect_done(input logic [15:0] a, input logic c);
        exp_q.push_back(mk(a, c));
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && bus.DONE) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("done_acc", 32'(bus.AH_ACC), 32'(e.acc));
                check("done_c",   32'(bus.C_FLAG), 32'(e.c));
                check("done_z",   32'(bus.Z_FLAG), 32'(e.z));
                check("done_n",   32'(bus.N_FLAG), 32'(e.n));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] d);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.D_IN  = d;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic finish_op(input int exp_busy, input string name);
        int b = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (!bus.BUSY) break;
            b++;
        end
        check(name, 32'(b), 32'(exp_busy));
        @(posedge CLK);
        #1;
    endtask

    task automatic single(input logic [2:0] op, input logic [15:0] d,
                          input logic [15:0] a, input logic c, input string name);
        expect_done(a, c);
        issue(op, d);
        finish_op(0, name);
    endtask

    task automatic mul_op(input logic [15:0] d, input logic [15:0] acc0, input string name);
        int b = 0;
        int bad = 0;
        issue(OP_MUL, d);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (!bus.BUSY) break;
            b++;
            if (bus.AH_ACC !== acc0) bad++;
        end
        check({name, "_busy"}, 32'(b), 32'd16);
        check({name, "_hold"}, 32'(bad), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.START = 1'b0;
        bus.OP    = OP_ADD;
        bus.D_IN  = 16'h0000;
        RESET     = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_acc",  32'(bus.AH_ACC), 32'h0);
        check("rst_busy", 32'(bus.BUSY),   32'h0);
        check("rst_done", 32'(bus.DONE),   32'h0);
        check("rst_flags", 32'({bus.C_FLAG, bus.Z_FLAG, bus.N_FLAG}), 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        single(OP_LOAD, 16'h1234, 16'h1234, 1'b0, "load_busy");
        single(OP_LOAD, 16'hFFFF, 16'hFFFF, 1'b0, "load2_busy");
        single(OP_ADD,  16'h0001, 16'h0000, 1'b1, "add_busy");
        single(OP_ADC,  16'h0000, 16'h0001, 1'b0, "adc_busy");
        single(OP_ADC,  16'h0002, 16'h0003, 1'b0, "adc2_busy");
        single(OP_LOAD, 16'h0003, 16'h0003, 1'b0, "load3_busy");
        single(OP_SUB,  16'h0005, 16'hFFFE, 1'b1, "sub_busy");
        single(OP_LOAD, 16'h0005, 16'h0005, 1'b0, "load5_busy");
        single(OP_SUB,  16'h0005, 16'h0000, 1'b0, "sub2_busy");
        single(OP_LOAD, 16'hF0F0, 16'hF0F0, 1'b0, "loadf_busy");
        single(OP_AND,  16'h3C3C, 16'h3030, 1'b0, "and_busy");
        single(OP_CLR,  16'h5555, 16'h0000, 1'b0, "clr_busy");

        // Back-to-back: the second START lands in the first op's DONE cycle.
        expect_done(16'h0010, 1'b0);
        expect_done(16'h0015, 1'b0);
        issue(OP_LOAD, 16'h0010);
        issue(OP_ADD,  16'h0005);
        finish_op(0, "b2b_busy");

        single(OP_LOAD, 16'h8001, 16'h8001, 1'b0, "load8_busy");
        expect_done(16'h0008, 1'b0);
        issue(OP_SHL, 16'h0003);
        bus.START = 1'b1;
        bus.OP    = OP_LOAD;
        bus.D_IN  = 16'hAAAA;
        @(negedge CLK);
        check("shl_b0_busy", 32'(bus.BUSY),   32'h1);
        check("shl_b0_acc",  32'(bus.AH_ACC), 32'h8001);
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        @(negedge CLK);
        check("shl_b1_acc", 32'(bus.AH_ACC), 32'h0002);
        check("shl_b1_c",   32'(bus.C_FLAG), 32'h1);
        check("shl_b1_busy", 32'(bus.BUSY),  32'h1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("shl_b2_acc", 32'(bus.AH_ACC), 32'h0004);
        check("shl_b2_c",   32'(bus.C_FLAG), 32'h0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("shl_end_busy", 32'(bus.BUSY), 32'h0);
        check("shl_end_done", 32'(bus.DONE), 32'h1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("shl_ignored_acc", 32'(bus.AH_ACC), 32'h0008);
        check("shl_done_once",   32'(bus.DONE),   32'h0);
        @(posedge CLK);
        #1;

        single(OP_SHL, 16'h0010, 16'h0008, 1'b0, "shl0_busy");

        single(OP_LOAD, 16'h0003, 16'h0003, 1'b0, "load3b_busy");
        expect_done(16'h8000, 1'b1);
        issue(OP_SHL, 16'h000F);
        finish_op(15, "shl15_busy");

        single(OP_LOAD, 16'h0012, 16'h0012, 1'b0, "load12_busy");
        expect_done(16'h03A8, 1'b0);
        mul_op(16'h0034, 16'h0012, "mul1");
        single(OP_LOAD, 16'h0100, 16'h0100, 1'b0, "load100_busy");
        expect_done(16'h0000, 1'b1);
        mul_op(16'h0300, 16'h0100, "mul2");
        single(OP_LOAD, 16'hFFFF, 16'hFFFF, 1'b0, "loadff_busy");
        expect_done(16'h0001, 1'b1);
        mul_op(16'hFFFF, 16'hFFFF, "mul3");

        // Abort a multiply in its fifth busy cycle; no DONE may follow.
        single(OP_LOAD, 16'h8007, 16'h8007, 1'b0, "load7_busy");
        issue(OP_MUL, 16'h0003);
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        check("abort_busy_before", 32'(bus.BUSY), 32'h1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_acc",   32'(bus.AH_ACC), 32'h0);
        check("abort_flags", 32'({bus.C_FLAG, bus.Z_FLAG, bus.N_FLAG}), 32'h0);
        check("abort_busy",  32'(bus.BUSY), 32'h0);
        check("abort_done",  32'(bus.DONE), 32'h0);
        repeat (25) @(posedge CLK);
        #1;
        single(OP_LOAD, 16'h0001, 16'h0001, 1'b0, "post_abort_busy");

        repeat (2) @(posedge CLK);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
